// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants, types and helpers for the LA32R instruction-fetch stage.
//   RESET_PC_VAL  : first fetch address after reset
//   INST_NOP_VAL  : bubble encoding (andi r0,r0,0)
//   fetch_act_e   : per-edge action chosen by the fetch stage
//   align_pc()    : force a jump target onto a word boundary
//   next_pc()     : sequential successor, 32-bit modulo
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_VAL = 32'h1C00_0000;
   localparam logic [31:0] INST_NOP_VAL = 32'h0340_0000;
   localparam int          INST_W       = 32;
   localparam int          DIN_LSB      = 15;

   // Encoded in priority order: reset beats redirect beats stall.
   typedef enum logic [1:0] {
      FETCH_RESET    = 2'd0,
      FETCH_REDIRECT = 2'd1,
      FETCH_STALL    = 2'd2,
      FETCH_ADVANCE  = 2'd3
   } fetch_act_e;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Wraps FFFF_FFFC -> 0000_0000 silently.
   function automatic logic [31:0] next_pc(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// ---------------------------------------------------------------------------
// fetch_skid_buf
// One-entry skid buffer for the IROM read data. The ROM has a fixed 1-cycle
// latency and cannot be paused, so the word returned during the first stall
// cycle must be parked here until decode accepts it.
// Ports:
//   clk        in   clock
//   capture    in   load rdata into the buffer (first stall cycle only)
//   clear      in   drop the buffered word (advance, redirect or reset)
//   rdata      in   IROM read data
//   skid_valid out  buffer holds a word
//   sel_inst   out  buffered word if held, otherwise live rdata
// ---------------------------------------------------------------------------
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              capture,
   input  logic              clear,
   input  logic [INST_W-1:0] rdata,
   output logic              skid_valid,
   output logic [INST_W-1:0] sel_inst
);

   logic [INST_W-1:0] skid_inst;

   // clear doubles as the reset path: the parent asserts it on reset edges.
   always_ff @(posedge clk) begin
      if (clear) begin
         skid_valid <= 1'b0;
      end else if (capture) begin
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clear && capture) begin
         skid_inst <= rdata;
      end
   end

   assign sel_inst = skid_valid ? skid_inst : rdata;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// LA32R instruction-fetch stage plus IF/ID pipeline register. Owns the PC,
// drives a synchronous-read IROM (1-cycle latency), absorbs decode stalls
// with a one-entry skid buffer and flushes on execute-stage redirects.
// Ports:
//   cpu_clk         in   clock
//   cpu_rst         in   synchronous active-high reset
//   irom_addr       out  byte address to IROM (the PC register)
//   irom_rdata      in   IROM data for last cycle's address
//   id_stall        in   decode cannot accept; hold IF/ID
//   redirect_valid  in   taken branch/jump from EX
//   redirect_pc     in   redirect target, low 2 bits ignored
//   id_valid        out  IF/ID holds a real instruction
//   id_pc           out  PC of id_inst
//   id_inst         out  instruction, INST_NOP when id_valid=0
//   id_din          out  id_inst[31:15] for the control unit
// ---------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_VAL,
   parameter logic [31:0] INST_NOP = INST_NOP_VAL
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   output logic [31:0] irom_addr,
   input  logic [31:0] irom_rdata,
   input  logic        id_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [16:0] id_din
);

   fetch_act_e        act;
   logic [31:0]       pc_p0;      // F1: address being presented to the ROM
   logic              vld_p1;     // F2: a request is in flight
   logic [31:0]       pc_p1;      // F2: address whose data is on irom_rdata
   logic              skid_valid;
   logic              skid_capture;
   logic              skid_clear;
   logic [31:0]       sel_inst;

   always_comb begin
      act = FETCH_ADVANCE;
      if (cpu_rst) begin
         act = FETCH_RESET;
      end else if (redirect_valid) begin
         act = FETCH_REDIRECT;
      end else if (id_stall) begin
         act = FETCH_STALL;
      end
   end

   // Capture only on the first stall cycle: after that irom_rdata reflects
   // the held PC, not pc_p1, and would overwrite the good word.
   assign skid_capture = (act == FETCH_STALL) && vld_p1 && !skid_valid;
   assign skid_clear   = (act != FETCH_STALL);

   fetch_skid_buf u_skid (
      .clk        (cpu_clk),
      .capture    (skid_capture),
      .clear      (skid_clear),
      .rdata      (irom_rdata),
      .skid_valid (skid_valid),
      .sel_inst   (sel_inst)
   );

   // ---- F1 -> F2 boundary ----
   always_ff @(posedge cpu_clk) begin
      unique case (act)
         FETCH_RESET: begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
         end
         FETCH_REDIRECT: begin
            pc_p0  <= align_pc(redirect_pc);
            vld_p1 <= 1'b0;
         end
         FETCH_STALL: begin
         end
         FETCH_ADVANCE: begin
            pc_p0  <= next_pc(pc_p0);
            vld_p1 <= 1'b1;
            pc_p1  <= pc_p0;
         end
         default: begin
         end
      endcase
   end

   // ---- F2 -> ID boundary ----
   always_ff @(posedge cpu_clk) begin
      unique case (act)
         FETCH_RESET: begin
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            id_inst  <= INST_NOP;
         end
         FETCH_REDIRECT: begin
            id_valid <= 1'b0;
            id_inst  <= INST_NOP;
         end
         FETCH_STALL: begin
         end
         FETCH_ADVANCE: begin
            id_valid <= vld_p1;
            id_pc    <= pc_p1;
            id_inst  <= vld_p1 ? sel_inst : INST_NOP;
         end
         default: begin
         end
      endcase
   end

   assign irom_addr = pc_p0;
   assign id_din    = id_inst[31:DIN_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0340_0000;
   localparam logic [31:0] RPC = 32'h1C00_0000;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic [31:0] irom_addr;
   logic [31:0] irom_rdata;
   logic        id_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [16:0] id_din;

   int checks = 0;
   int failures = 0;

   fetch_stage dut (
      .cpu_clk        (cpu_clk),
      .cpu_rst        (cpu_rst),
      .irom_addr      (irom_addr),
      .irom_rdata     (irom_rdata),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_inst        (id_inst),
      .id_din         (id_din)
   );

   always #5 cpu_clk = ~cpu_clk;

   // Synchronous ROM: mem[A] = A ^ 32'h5A5A
   always @(posedge cpu_clk) irom_rdata <= irom_addr ^ 32'h0000_5A5A;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ev;
      logic        chk_pc;
      logic [31:0] epc;
      logic [31:0] eaddr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] rpc, input logic ev, input logic chk_pc,
                      input logic [31:0] epc, input logic [31:0] eaddr);
      vec_t v;
      v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
      v.ev = ev; v.chk_pc = chk_pc; v.epc = epc; v.eaddr = eaddr;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, clock, then check outputs just after the edge.
   task automatic step(input string tag, input logic rst, input logic stall,
                       input logic redir, input logic [31:0] rpc,
                       input logic ev, input logic chk_pc,
                       input logic [31:0] epc, input logic [31:0] eaddr);
      logic [31:0] einst;
      cpu_rst = rst; id_stall = stall; redirect_valid = redir; redirect_pc = rpc;
      @(posedge cpu_clk);
      #1;
      einst = ev ? (epc ^ 32'h0000_5A5A) : NOP;
      chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, ev});
      chk({tag, ".addr"}, irom_addr, eaddr);
      chk({tag, ".inst"}, id_inst, einst);
      chk({tag, ".din"}, {15'd0, id_din}, {15'd0, einst[31:15]});
      if (chk_pc) chk({tag, ".pc"}, id_pc, epc);
   endtask

   initial begin
      // Scenario 1: reset and first fetches
      add(1,0,0,0,            0,1,32'h0,         RPC);
      add(0,0,0,0,            0,0,0,             RPC+4);
      add(0,0,0,0,            1,1,RPC,           RPC+8);
      add(0,0,0,0,            1,1,RPC+4,         RPC+12);
      add(0,0,0,0,            1,1,RPC+8,         RPC+16);
      // Scenario 2: 3-cycle stall at 1C00_0008
      add(0,1,0,0,            1,1,RPC+8,         RPC+16);
      add(0,1,0,0,            1,1,RPC+8,         RPC+16);
      add(0,1,0,0,            1,1,RPC+8,         RPC+16);
      add(0,0,0,0,            1,1,RPC+12,        RPC+20);
      add(0,0,0,0,            1,1,RPC+16,        RPC+24);
      // Scenario 3: unaligned redirect
      add(0,0,1,32'h1C00_0103,0,0,0,             32'h1C00_0100);
      add(0,0,0,0,            0,0,0,             32'h1C00_0104);
      add(0,0,0,0,            1,1,32'h1C00_0100, 32'h1C00_0108);
      add(0,0,0,0,            1,1,32'h1C00_0104, 32'h1C00_010C);
      // Scenario 4: redirect while stalled with skid full
      add(0,1,0,0,            1,1,32'h1C00_0104, 32'h1C00_010C);
      add(0,1,0,0,            1,1,32'h1C00_0104, 32'h1C00_010C);
      add(0,1,1,32'h1C00_0200,0,0,0,             32'h1C00_0200);
      add(0,0,0,0,            0,0,0,             32'h1C00_0204);
      add(0,0,0,0,            1,1,32'h1C00_0200, 32'h1C00_0208);
      add(0,0,0,0,            1,1,32'h1C00_0204, 32'h1C00_020C);
      // Scenario 5: reset pulse while stalled at 1C00_0040
      add(0,0,1,32'h1C00_0040,0,0,0,             32'h1C00_0040);
      add(0,0,0,0,            0,0,0,             32'h1C00_0044);
      add(0,0,0,0,            1,1,32'h1C00_0040, 32'h1C00_0048);
      add(1,1,0,0,            0,1,32'h0,         RPC);
      add(0,0,0,0,            0,0,0,             RPC+4);
      add(0,0,0,0,            1,1,RPC,           RPC+8);
      add(0,0,0,0,            1,1,RPC+4,         RPC+12);
      // Scenario 6: PC wrap
      add(0,0,1,32'hFFFF_FFFC,0,0,0,             32'hFFFF_FFFC);
      add(0,0,0,0,            0,0,0,             32'h0000_0000);
      add(0,0,0,0,            1,1,32'hFFFF_FFFC, 32'h0000_0004);
      add(0,0,0,0,            1,1,32'h0000_0000, 32'h0000_0008);
      add(0,0,0,0,            1,1,32'h0000_0004, 32'h0000_000C);

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("v%0d", i), tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc,
              tbl[i].ev, tbl[i].chk_pc, tbl[i].epc, tbl[i].eaddr);
      end

      // Long stall: nothing lost, nothing duplicated
      for (int i = 0; i < 5; i++)
         step($sformatf("long_stall%0d", i), 0,1,0,0, 1,1,32'h0000_0004, 32'h0000_000C);
      step("long_rel0", 0,0,0,0, 1,1,32'h0000_0008, 32'h0000_0010);
      step("long_rel1", 0,0,0,0, 1,1,32'h0000_000C, 32'h0000_0014);
      step("long_rel2", 0,0,0,0, 1,1,32'h0000_0010, 32'h0000_0018);

      // Stall while no request is in flight (right after a redirect)
      step("bub_redir", 0,0,1,32'h1C00_0300, 0,0,0, 32'h1C00_0300);
      step("bub_stall0", 0,1,0,0, 0,0,0, 32'h1C00_0300);
      step("bub_stall1", 0,1,0,0, 0,0,0, 32'h1C00_0300);
      step("bub_rel0", 0,0,0,0, 0,0,0, 32'h1C00_0304);
      step("bub_rel1", 0,0,0,0, 1,1,32'h1C00_0300, 32'h1C00_0308);
      step("bub_rel2", 0,0,0,0, 1,1,32'h1C00_0304, 32'h1C00_030C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the LA32R pipeline; feeds the decode stage, whose control unit consumes bits [31:15] of the instruction.
Owns the PC and drives a synchronous-read instruction ROM with 1-cycle read latency.
Handles decode-stage stalls with a one-entry skid buffer and handles execute-stage redirects by flushing.
Presents a NOP bubble to decode whenever no valid instruction is held.

Parameters:
RESET_PC, 32'h1C00_0000, first fetch address after reset.
INST_NOP, 32'h0340_0000, bubble encoding (andi r0,r0,0) driven on id_inst when id_valid=0.

Ports:
cpu_clk  in  1  clock; all state updates on the rising edge.
cpu_rst  in  1  reset; synchronous, active-high.
irom_addr  out  32  byte address to IROM; equals the PC register.
irom_rdata  in  32  IROM data for the address presented on the previous cycle.
id_stall  in  1  decode cannot accept this cycle; hold the IF/ID contents.
redirect_valid  in  1  taken branch/jump resolved in EX.
redirect_pc  in  32  target; bits [1:0] ignored and forced to 00.
id_valid  out  1  IF/ID holds a real instruction.
id_pc  out  32  PC of id_inst.
id_inst  out  32  instruction; equals INST_NOP when id_valid=0.
id_din  out  17  id_inst[31:15], straight to control-unit din.

Behaviour:
- State:
  - pc (F1): drives irom_addr.
  - req_valid/req_pc (F2): the address whose data is on irom_rdata this cycle.
  - skid_valid/skid_inst: ROM data captured during a stall.
  - IF/ID: id_valid, id_pc, id_inst.
- Reset (cpu_rst=1 at an edge), which overrides every other input:
  - pc=RESET_PC, req_valid=0, skid_valid=0.
  - id_valid=0, id_pc=0, id_inst=INST_NOP.
  - Applies identically when asserted mid-operation.
- Latency: reset released at edge 0 → edge 1 issues RESET_PC to F2 → edge 2 gives id_valid=1, id_pc=RESET_PC.
- Priority per edge: cpu_rst > redirect_valid > id_stall > normal advance.
- Redirect:
  - pc=redirect_pc&~3, req_valid=0, skid_valid=0, id_valid=0 (id_inst=INST_NOP).
  - Applies regardless of id_stall.
  - The first valid redirect-target instruction reaches ID 2 edges later.
- Stall (redirect_valid=0):
  - pc, req_* and IF/ID hold.
  - If req_valid=1 and skid_valid=0, then skid_inst=irom_rdata and skid_valid=1; this is the only cycle irom_rdata matches req_pc.
  - Later stall cycles leave the skid unchanged.
- Advance (no stall, no redirect):
  - id_valid=req_valid, id_pc=req_pc.
  - id_inst = skid_inst if skid_valid, else irom_rdata; forced to INST_NOP when req_valid=0.
  - skid_valid=0, req_valid=1, req_pc=pc, pc=pc+4.
- Arithmetic: pc+4 is 32-bit modulo; wrap 32'hFFFF_FFFC→0 is allowed and not flagged.
- Consecutive stalls of any length lose no instruction and duplicate none.
- The ID sequence equals program order, with bubbles only after reset or redirect.
- id_din is always a combinational slice of id_inst; there is no extra register.

Decomposition:
- defines.vh gains RESET_PC_VAL and INST_NOP macros next to the existing NPC/EXT encodings; the parameter defaults use these macros.
- One natural sub-module: fetch_skid_buf (skid_valid/skid_inst plus output-select mux; inputs capture, clear, rdata).
- PC and IF/ID registers stay in fetch_stage.

Test Plan:
1. Reset release, ROM holds mem[A]=A^32'h5A5A: id_valid=0 at edges 0–1. Edge 2: id_pc=1C00_0000, id_inst=mem[1C00_0000]. Edge 3: id_pc=1C00_0004. Bubble cycles show id_inst=0340_0000 and id_din=id_inst[31:15].
2. Steady flow, id_stall high 3 cycles while id_pc=1C00_0008: IF/ID holds 1C00_0008 for 3 edges. After release, id_pc is 1C00_000C then 1C00_0010 with correct data; no skip, no duplicate.
3. redirect_valid=1, redirect_pc=1C00_0103 for one cycle: next edge id_valid=0 and irom_addr=1C00_0100. Two edges later id_pc=1C00_0100, then 1C00_0104.
4. redirect_valid and id_stall both high while skid_valid=1: redirect wins; skid cleared, id_valid=0. The first ID after the flush is the target, not the stale skid word.
5. cpu_rst pulsed 1 cycle while id_stall=1 and id_valid=1 at 1C00_0040: next edge id_valid=0, irom_addr=1C00_0000. Restart matches scenario 1.
6. pc preloaded via redirect to FFFF_FFFC, no stalls: id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
